// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: two requesters share one WIDTH-bit register through a
// four-state grant/write handshake with alternating priority under contention.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req0, req1   write requests
//   d0, d1       write data, sampled only on the WRITE->DONE edge
//   gnt0, gnt1   registered one-hot grant
//   ack          registered one-cycle write-complete pulse
//   busy         high whenever the FSM is not IDLE
//   q            shared register contents
//   q_par        (REG_SHARE_PARITY_EN only) XOR of all bits of q
//
// Optional feature macro: REG_SHARE_PARITY_EN adds the q_par output.

module reg_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack,
    output logic             busy,
`ifdef REG_SHARE_PARITY_EN
    output logic [WIDTH-1:0] q,
    output logic             q_par
`else
    output logic [WIDTH-1:0] q
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    // ptr=0 favours requester 0 when both request.
    logic             ptr;
    logic             pick1;
    logic             held;
    logic [WIDTH-1:0] wdata;

    // Requester 1 wins if it is alone, or if both ask and ptr favours it.
    assign pick1 = req1 & (~req0 | ptr);
    // The grant registers double as the winner index during a transaction.
    assign held  = gnt1 ? req1 : req0;
    assign wdata = gnt1 ? d1 : d0;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            ack   <= 1'b0;
            ptr   <= 1'b0;
            q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (held) begin
                        state <= WRITE;
                    end else begin
                        // Request withdrawn: abort, pointer untouched.
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    q     <= wdata;
                    ack   <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    ack   <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    // Next contention favours whoever did not just win.
                    ptr   <= gnt0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REG_SHARE_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_par <= 1'b0;
        end else if (state == WRITE) begin
            q_par <= ^wdata;
        end
    end
`endif

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: directed scenarios then random
// traffic, checked against a transaction-age reference model.

module tb_reg_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       gnt0;
    logic       gnt1;
    logic       ack;
    logic       busy;
    logic [7:0] q;
    logic       par;

    reg_share_arbiter #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .d0   (d0),
        .d1   (d1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .ack  (ack),
        .busy (busy),
`ifdef REG_SHARE_PARITY_EN
        .q    (q),
        .q_par(par)
`else
        .q    (q)
`endif
    );

`ifndef REG_SHARE_PARITY_EN
    assign par = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       ack;
        logic       busy;
        logic [7:0] q;
        logic       par;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_wr[$];
    logic [7:0] wr_log[$];

    int checks = 0;
    int errors = 0;

    // Reference model: a transaction is "active" with a winner and an age
    // counted in edges since the grant.
    bit         m_act;
    int         m_age;
    bit         m_win;
    bit         m_ptr;
    logic [7:0] m_q;
    bit         m_par;

    function automatic exp_t snap();
        exp_t e;
        e.g0   = m_act && !m_win;
        e.g1   = m_act && m_win;
        e.ack  = m_act && (m_age == 2);
        e.busy = m_act;
        e.q    = m_q;
`ifdef REG_SHARE_PARITY_EN
        e.par  = m_par;
`else
        e.par  = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_act = 0;
        m_age = 0;
        m_win = 0;
        m_ptr = 0;
        m_q   = 8'h00;
        m_par = 0;
    endtask

    task automatic model_edge();
        if (!m_act) begin
            if (req0 || req1) begin
                m_win = (req0 && req1) ? m_ptr : req1;
                m_act = 1;
                m_age = 0;
            end
        end else begin
            m_age++;
            if (m_age == 1) begin
                if (!(m_win ? req1 : req0)) m_act = 0;
            end else if (m_age == 2) begin
                m_q   = m_win ? d1 : d0;
                m_par = ^m_q;
                exp_wr.push_back(m_q);
            end else if (m_age == 3) begin
                m_ptr = !m_win;
                m_act = 0;
            end
        end
    endtask

    task automatic step(input logic r0, input logic r1,
                        input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        d0   = a;
        d1   = b;
        if (rst) model_edge();
        exp_q.push_back(snap());
    endtask

    task automatic check_zero(input string name);
        exp_t act;
        act = '{gnt0, gnt1, ack, busy, q, par};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s: got %h want 0", name, act);
        end
    endtask

    // Asserts reset at a negedge, checks the asynchronous clear, holds it
    // across one posedge and releases it at the following negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        exp_q.push_back(snap());
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(snap());
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Monitor: compares each cycle's outputs and every acked write.
    always begin
        exp_t e;
        exp_t act;
        @(posedge clk);
        #1;
        act = '{gnt0, gnt1, ack, busy, q, par};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle %0t: got %h want %h", $time, act, e);
            end
        end
        checks++;
        if (gnt0 && gnt1) begin
            errors++;
            $display("FAIL onehot: got gnt0=1 gnt1=1 want at most one");
        end
        if (ack) begin
            wr_log.push_back(q);
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got q=%h want no ack", q);
            end else begin
                e.q = exp_wr.pop_front();
                if (q !== e.q) begin
                    errors++;
                    $display("FAIL write: got %h want %h", q, e.q);
                end
            end
        end
    end

    logic [7:0] dir_exp[9];

    initial begin
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        d0   = 8'h00;
        d1   = 8'h00;
        model_reset();
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // Single request.
        repeat (4) step(1, 0, 8'hA5, 8'h00);
        step(0, 0, 8'h00, 8'h00);
        // Abort by requester 1, then contention grants requester 1 first.
        step(0, 1, 8'h00, 8'h99);
        step(0, 0, 8'h00, 8'h99);
        repeat (4) step(1, 1, 8'h33, 8'h44);
        step(0, 0, 8'h00, 8'h00);
        // Reset while in WRITE.
        repeat (2) step(1, 0, 8'h55, 8'h00);
        do_reset();
        // Contention from reset: 11, 22, 11.
        repeat (12) step(1, 1, 8'h11, 8'h22);
        step(0, 0, 8'h00, 8'h00);
        // Request 1 raised while busy is ignored until IDLE.
        step(1, 0, 8'h66, 8'h77);
        repeat (3) step(1, 1, 8'h66, 8'h77);
        repeat (4) step(0, 1, 8'h00, 8'h77);
        // Parity values.
        repeat (4) step(1, 0, 8'h07, 8'h00);
        repeat (4) step(0, 1, 8'h00, 8'h03);
        step(0, 0, 8'h00, 8'h00);
        @(posedge clk);
        #2;

        dir_exp = '{8'hA5, 8'h44, 8'h11, 8'h22, 8'h11,
                    8'h66, 8'h77, 8'h07, 8'h03};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= wr_log.size()) begin
                errors++;
                $display("FAIL dir_write%0d: got none want %h", i, dir_exp[i]);
            end else if (wr_log[i] !== dir_exp[i]) begin
                errors++;
                $display("FAIL dir_write%0d: got %h want %h",
                         i, wr_log[i], dir_exp[i]);
            end
        end

        // Random traffic obeying the hold rule for the granted requester.
        for (int i = 0; i < 1500; i++) begin
            logic       r0;
            logic       r1;
            logic [7:0] a;
            logic [7:0] b;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (m_act && m_age < 2) begin
                if (!m_win) begin
                    r0 = (m_age == 0 && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                    a  = d0;
                end else begin
                    r1 = (m_age == 0 && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                    b  = d1;
                end
            end
            step(r0, r1, a, b);
        end
        step(0, 0, 8'h00, 8'h00);
        @(posedge clk);
        #2;

        checks++;
        if (exp_q.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending want 0/0",
                     exp_q.size(), exp_wr.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
